pong_score_keeper: RTL and testbench
====================================

# pong_score_keeper

Game-state and scoring block for Pong. Consumes the ball position published by the ball controller and both paddle positions, detects misses at the left and right walls, and keeps both players' scores. It sequences serve, point-hold and game-over, and gates the ball controller through `ball_enable`, which drives the controller's active-low reset. It also produces the registered ball-pixel strobe for the video mux.

## Interface
- `GAME_WIDTH`, 40: board columns; the ball's x range is 0..GAME_WIDTH-1.
- `GAME_HEIGHT`, 30: board rows.
- `PADDLE_HEIGHT`, 6: paddle length in rows.
- `WIN_SCORE`, 9: score that ends the game (1..15).
- `POINT_HOLD`, 25000000: cycles the ball is held at centre after a point (1 s at 25 MHz).

Ports:
- `clock`  in  1: system clock, 25 MHz.
- `reset`  in  1: reset, synchronous and active-high.
- `start`  in  1: level, sampled each cycle; begins or restarts a game.
- `ball_x`  in  6: ball column from the ball controller.
- `ball_y`  in  6: ball row from the ball controller.
- `paddle1_y`  in  6: top row of the left paddle (column 0).
- `paddle2_y`  in  6: top row of the right paddle (column GAME_WIDTH-1).
- `column_count`  in  6: current draw column, in game units.
- `row_count`  in  6: current draw row, in game units.
- `ball_enable`  out  1: 1 lets the ball move; 0 holds it at centre.
- `score1`  out  4: left player score.
- `score2`  out  4: right player score.
- `point_pulse`  out  1: one-cycle strobe when a point is scored.
- `game_active`  out  1: 1 in RUNNING or POINT.
- `winner`  out  2: 0 = none, 1 = left player won, 2 = right player won.
- `draw_ball`  out  1: 1 when the draw position equals the ball position.

## Operation
- States: IDLE, RUNNING, POINT, GAME_OVER.
- Reset forces IDLE and zeroes every output. This applies mid-game too; no partial state survives.
- **IDLE:** `ball_enable`=0. When `start`=1, go to RUNNING.
- **RUNNING:** `ball_enable`=1. `start` is ignored.
- **Position events:** `prev_x`/`prev_y` registers hold the last sampled ball position. A position event occurs on any cycle where `ball_x`≠`prev_x` or `ball_y`≠`prev_y`. Misses are evaluated only on a position event while in RUNNING, so each ball arrival is counted at most once.
- **Hit test:** the test is done at 7 bits, with no wrap. A ball is on paddle p iff `ball_y` ≥ `paddleP_y` and `ball_y` < `paddleP_y` + PADDLE_HEIGHT.
- **Left miss:** `ball_x`==0 and the ball is not on paddle1. `score2` increments and the next state is POINT.
- **Right miss:** `ball_x`==GAME_WIDTH-1 and the ball is not on paddle2. `score1` increments and the next state is POINT.
- Both misses in one event cannot occur, since GAME_WIDTH ≥ 2.
- **POINT:** `ball_enable`=0, so the controller recentres the ball. Position events caused by the recentre are ignored. The hold counter counts POINT_HOLD cycles, then the next state is RUNNING. If a score has reached WIN_SCORE, the next state is GAME_OVER instead, entered directly from the scoring cycle with no hold.
- **GAME_OVER:** `ball_enable`=0 and `winner` is set. When `start`=1, both scores and `winner` clear and the next state is RUNNING.
- **Score saturation:** scores saturate at WIN_SCORE and never wrap.
- **`draw_ball`:** equals (`column_count`==`ball_x` && `row_count`==`ball_y`), registered. It is valid in all states except IDLE, where it is 0.

## Timing
- **Miss detected in cycle N** (inputs sampled at edge N). At edge N+1:
  - the score updates;
  - `point_pulse`=1 for exactly one cycle (N+1 only);
  - `ball_enable`=0;
  - the state becomes POINT or GAME_OVER.
- **Hold length:** `ball_enable` is 0 for exactly POINT_HOLD cycles, N+1 through N+POINT_HOLD, and is 1 again at N+POINT_HOLD+1.
- **Start:** `start` asserted in cycle S from IDLE or GAME_OVER gives `ball_enable`=1 at S+1. Scores are cleared at S+1 in the GAME_OVER case.
- **`draw_ball` latency:** one cycle from `column_count`/`row_count`.
- **`winner` and `game_active`:** update on the same edge as the state change.
- **Reset:** a reset in any cycle produces all outputs 0 on the next edge. This overrides a simultaneous `start` or miss.

## Test plan
Bench uses POINT_HOLD=4 and WIN_SCORE=3.
- **Start from reset:** reset, then `start` for 1 cycle → `ball_enable`=1 one cycle later; scores 0/0; `game_active`=1.
- **Left miss:** `paddle1_y`=10, ball moves to (0,5) → `score2`=1; `point_pulse` for 1 cycle; `ball_enable`=0 for exactly 4 cycles. The recentre to (20,15) does not score.
- **Right-edge hit boundary:** `paddle2_y`=10, ball at (39,15) → no score. `paddle2_y`=10, ball at (39,16) → `score1`+1.
- **Ball held at the wall:** ball held at (0,5) for 10 cycles with no position change → exactly one point.
- **Game over and restart:** three right-player points → GAME_OVER; `winner`=2; `score2`=3; `ball_enable` stays 0. Then `start` → scores 0/0 and RUNNING.
- **Reset mid-hold:** reset during POINT → IDLE next cycle; all outputs 0. `start` is ignored on the reset cycle.

Source files
------------

// File: rtl/pong_score_keeper_if.sv
// Game-side signal bundle for the Pong score keeper: ball/paddle positions and
// draw coordinates in, game state and scores out.
interface pong_score_keeper_if;
   logic       start;
   logic [5:0] ball_x;
   logic [5:0] ball_y;
   logic [5:0] paddle1_y;
   logic [5:0] paddle2_y;
   logic [5:0] column_count;
   logic [5:0] row_count;
   logic       ball_enable;
   logic [3:0] score1;
   logic [3:0] score2;
   logic       point_pulse;
   logic       game_active;
   logic [1:0] winner;
   logic       draw_ball;

   // Game/video side: drives positions and start, observes game state.
   modport master (
      output start, ball_x, ball_y, paddle1_y, paddle2_y, column_count, row_count,
      input  ball_enable, score1, score2, point_pulse, game_active, winner, draw_ball
   );

   // Score keeper side.
   modport slave (
      input  start, ball_x, ball_y, paddle1_y, paddle2_y, column_count, row_count,
      output ball_enable, score1, score2, point_pulse, game_active, winner, draw_ball
   );
endinterface

// File: rtl/pong_score_keeper.sv
// Pong game sequencer: detects wall misses on ball position changes, keeps both
// scores, runs serve / point-hold / game-over and gates the ball controller.
module pong_score_keeper #(
   parameter int GAME_WIDTH    = 40,
   parameter int GAME_HEIGHT   = 30,
   parameter int PADDLE_HEIGHT = 6,
   parameter int WIN_SCORE     = 9,
   parameter int POINT_HOLD    = 25000000
) (
   input  logic                 clock,
   input  logic                 reset,
   pong_score_keeper_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE,
      RUNNING,
      POINT,
      GAME_OVER
   } state_t;

   localparam int                HOLD_W    = $clog2(POINT_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(POINT_HOLD - 1);
   localparam logic [3:0]        WIN       = 4'(WIN_SCORE);
   localparam logic [5:0]        RIGHT_X   = 6'(GAME_WIDTH - 1);
   localparam logic [6:0]        PAD_H     = 7'(PADDLE_HEIGHT);

   state_t              r_state;
   logic [HOLD_W-1:0]   r_hold_cnt;
   logic [5:0]          r_prev_x;
   logic [5:0]          r_prev_y;
   logic                r_ball_enable;
   logic [3:0]          r_score1;
   logic [3:0]          r_score2;
   logic                r_point_pulse;
   logic                r_game_active;
   logic [1:0]          r_winner;
   logic                r_draw_ball;

   logic                w_pos_event;
   logic [6:0]          w_ball_y7;
   logic [6:0]          w_pad1_top;
   logic [6:0]          w_pad2_top;
   logic                w_on_paddle1;
   logic                w_on_paddle2;
   logic                w_left_miss;
   logic                w_right_miss;
   logic [3:0]          w_score1_sat;
   logic [3:0]          w_score2_sat;
   logic                w_game_won;
   logic                w_pix_match;
   logic                w_unused_height;

   // Board height only sizes the row range seen by the ball controller.
   assign w_unused_height = (GAME_HEIGHT > 0);

   // A miss counts once per ball arrival: only when the sampled position moves.
   assign w_pos_event = (bus.ball_x != r_prev_x) || (bus.ball_y != r_prev_y);

   // Hit window compared at 7 bits so a paddle near row 63 does not wrap.
   assign w_ball_y7    = {1'b0, bus.ball_y};
   assign w_pad1_top   = {1'b0, bus.paddle1_y};
   assign w_pad2_top   = {1'b0, bus.paddle2_y};
   assign w_on_paddle1 = (w_ball_y7 >= w_pad1_top) && (w_ball_y7 < w_pad1_top + PAD_H);
   assign w_on_paddle2 = (w_ball_y7 >= w_pad2_top) && (w_ball_y7 < w_pad2_top + PAD_H);

   assign w_left_miss  = w_pos_event && (bus.ball_x == 6'd0)    && !w_on_paddle1;
   assign w_right_miss = w_pos_event && (bus.ball_x == RIGHT_X) && !w_on_paddle2;

   assign w_score1_sat = (r_score1 < WIN) ? r_score1 + 4'd1 : r_score1;
   assign w_score2_sat = (r_score2 < WIN) ? r_score2 + 4'd1 : r_score2;
   assign w_game_won   = (w_left_miss  && (w_score2_sat == WIN)) ||
                         (w_right_miss && (w_score1_sat == WIN));

   assign w_pix_match  = (bus.column_count == bus.ball_x) && (bus.row_count == bus.ball_y);

   // NOTE: every register here, including the position history and hold counter,
   // is cleared by the synchronous reset so a mid-game reset leaves nothing behind;
   // all updates use <= so each branch sees the pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= IDLE;
         r_hold_cnt    <= '0;
         r_prev_x      <= '0;
         r_prev_y      <= '0;
         r_ball_enable <= 1'b0;
         r_score1      <= '0;
         r_score2      <= '0;
         r_point_pulse <= 1'b0;
         r_game_active <= 1'b0;
         r_winner      <= '0;
         r_draw_ball   <= 1'b0;
      end else begin
         r_prev_x      <= bus.ball_x;
         r_prev_y      <= bus.ball_y;
         r_point_pulse <= 1'b0;
         r_draw_ball   <= w_pix_match;

         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_state       <= RUNNING;
                  r_ball_enable <= 1'b1;
                  r_game_active <= 1'b1;
               end else begin
                  r_draw_ball   <= 1'b0;
               end
            end

            RUNNING: begin
               if (w_left_miss || w_right_miss) begin
                  if (w_left_miss) begin
                     r_score2 <= w_score2_sat;
                  end else begin
                     r_score1 <= w_score1_sat;
                  end
                  r_point_pulse <= 1'b1;
                  r_ball_enable <= 1'b0;
                  if (w_game_won) begin
                     // Winning point skips the hold entirely.
                     r_state       <= GAME_OVER;
                     r_game_active <= 1'b0;
                     r_winner      <= w_left_miss ? 2'd2 : 2'd1;
                  end else begin
                     r_state       <= POINT;
                     r_hold_cnt    <= HOLD_LOAD;
                  end
               end
            end

            POINT: begin
               if (r_hold_cnt == '0) begin
                  r_state       <= RUNNING;
                  r_ball_enable <= 1'b1;
               end else begin
                  r_hold_cnt    <= r_hold_cnt - 1'b1;
               end
            end

            GAME_OVER: begin
               if (bus.start) begin
                  r_state       <= RUNNING;
                  r_score1      <= '0;
                  r_score2      <= '0;
                  r_winner      <= '0;
                  r_ball_enable <= 1'b1;
                  r_game_active <= 1'b1;
               end
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.ball_enable = r_ball_enable;
   assign bus.score1      = r_score1;
   assign bus.score2      = r_score2;
   assign bus.point_pulse = r_point_pulse;
   assign bus.game_active = r_game_active;
   assign bus.winner      = r_winner;
   assign bus.draw_ball   = r_draw_ball;

endmodule

// File: tb/tb_pong_score_keeper.sv
// Bench for pong_score_keeper: directed vector table, multi-cycle corner
// sequences, then random play compared against a rule-level game model.
module tb_pong_score_keeper;

   localparam int HOLD = 4;
   localparam int WIN  = 3;
   localparam int GW   = 40;
   localparam int PH   = 6;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_HOLD = 2;
   localparam int M_OVER = 3;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   pong_score_keeper_if bus();

   pong_score_keeper #(
      .GAME_WIDTH    (GW),
      .GAME_HEIGHT   (30),
      .PADDLE_HEIGHT (PH),
      .WIN_SCORE     (WIN),
      .POINT_HOLD    (HOLD)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Output bundle layout: {ball_enable, score1, score2, point_pulse, game_active, winner, draw_ball}
   function automatic logic [31:0] pack(input int en, input int s1, input int s2,
                                        input int pulse, input int act, input int win, input int draw);
      logic [13:0] v;
      v = {1'(en), 4'(s1), 4'(s2), 1'(pulse), 1'(act), 2'(win), 1'(draw)};
      return {18'd0, v};
   endfunction

   function automatic logic [31:0] dut_bundle();
      return {18'd0, bus.ball_enable, bus.score1, bus.score2, bus.point_pulse,
              bus.game_active, bus.winner, bus.draw_ball};
   endfunction

   // Rule-level game model: mode, scores, remaining disabled cycles, last ball position.
   int m_mode = M_IDLE;
   int m_s1 = 0, m_s2 = 0, m_win = 0, m_pulse = 0, m_left = 0;
   int m_px = 0, m_py = 0, m_draw = 0;

   task automatic model_edge();
      int bx, by, p1, p2;
      bit lm, rm;
      bx = int'(bus.ball_x);
      by = int'(bus.ball_y);
      p1 = int'(bus.paddle1_y);
      p2 = int'(bus.paddle2_y);
      m_pulse = 0;
      if (reset) begin
         m_mode = M_IDLE;
         m_s1 = 0; m_s2 = 0; m_win = 0;
      end else begin
         case (m_mode)
            M_IDLE: if (bus.start) m_mode = M_RUN;
            M_RUN: begin
               if (bx != m_px || by != m_py) begin
                  lm = (bx == 0)      && !(by >= p1 && by < p1 + PH);
                  rm = (bx == GW - 1) && !(by >= p2 && by < p2 + PH);
                  if (lm) m_s2 = (m_s2 + 1 > WIN) ? WIN : m_s2 + 1;
                  if (rm) m_s1 = (m_s1 + 1 > WIN) ? WIN : m_s1 + 1;
                  if (lm || rm) begin
                     m_pulse = 1;
                     if (m_s1 >= WIN) begin m_mode = M_OVER; m_win = 1; end
                     else if (m_s2 >= WIN) begin m_mode = M_OVER; m_win = 2; end
                     else begin m_mode = M_HOLD; m_left = HOLD; end
                  end
               end
            end
            M_HOLD: begin
               m_left = m_left - 1;
               if (m_left == 0) m_mode = M_RUN;
            end
            default: if (bus.start) begin
               m_s1 = 0; m_s2 = 0; m_win = 0; m_mode = M_RUN;
            end
         endcase
      end
      m_draw = (m_mode != M_IDLE && !reset && bus.column_count == bus.ball_x && bus.row_count == bus.ball_y) ? 1 : 0;
      m_px = bx;
      m_py = by;
   endtask

   function automatic logic [31:0] model_bundle();
      return pack((m_mode == M_RUN) ? 1 : 0, m_s1, m_s2, m_pulse,
                  (m_mode == M_RUN || m_mode == M_HOLD) ? 1 : 0, m_win, m_draw);
   endfunction

   task automatic drive(input bit rst, input bit st, input int bx, input int by,
                        input int p1, input int p2, input int col, input int row);
      reset            = rst;
      bus.start        = st;
      bus.ball_x       = 6'(bx);
      bus.ball_y       = 6'(by);
      bus.paddle1_y    = 6'(p1);
      bus.paddle2_y    = 6'(p2);
      bus.column_count = 6'(col);
      bus.row_count    = 6'(row);
   endtask

   task automatic step();
      model_edge();
      @(posedge clock);
      #1;
   endtask

   typedef struct {
      string name;
      bit    rst, st;
      int    bx, by, p1, p2, col, row;
      int    en, s1, s2, pulse, act, win, draw;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input string name, input bit rst, input bit st, input int bx, input int by,
                      input int p1, input int p2, input int col, input int row,
                      input int en, input int s1, input int s2, input int pulse,
                      input int act, input int win, input int draw);
      vec_t v;
      v.name = name; v.rst = rst; v.st = st; v.bx = bx; v.by = by;
      v.p1 = p1; v.p2 = p2; v.col = col; v.row = row;
      v.en = en; v.s1 = s1; v.s2 = s2; v.pulse = pulse; v.act = act; v.win = win; v.draw = draw;
      tbl.push_back(v);
   endtask

   initial begin
      int pulses, zeros, bx, by, p1, p2;

      //   name               rst st  bx  by  p1  p2 col row   en s1 s2 pl ac wn dr
      add("rst_with_start",    1, 1, 20, 15, 10, 10, 50, 50,   0, 0, 0, 0, 0, 0, 0);
      add("idle_no_draw",      0, 0, 20, 15, 10, 10, 20, 15,   0, 0, 0, 0, 0, 0, 0);
      add("start",             0, 1, 20, 15, 10, 10, 20, 15,   1, 0, 0, 0, 1, 0, 1);
      add("move_no_miss",      0, 0, 21, 15, 10, 10, 20, 15,   1, 0, 0, 0, 1, 0, 0);
      add("left_miss",         0, 0,  0,  5, 10, 10, 50, 50,   0, 0, 1, 1, 1, 0, 0);
      add("recentre_ignored",  0, 0, 20, 15, 10, 10, 50, 50,   0, 0, 1, 0, 1, 0, 0);
      add("hold_3",            0, 0, 20, 15, 10, 10, 50, 50,   0, 0, 1, 0, 1, 0, 0);
      add("hold_4",            0, 0, 20, 15, 10, 10, 50, 50,   0, 0, 1, 0, 1, 0, 0);
      add("hold_release",      0, 0, 20, 15, 10, 10, 50, 50,   1, 0, 1, 0, 1, 0, 0);
      add("right_hit_edge",    0, 0, 39, 15, 10, 10, 50, 50,   1, 0, 1, 0, 1, 0, 0);
      add("right_miss_edge",   0, 0, 39, 16, 10, 10, 50, 50,   0, 1, 1, 1, 1, 0, 0);
      add("r_hold_2",          0, 0, 20, 15, 10, 10, 50, 50,   0, 1, 1, 0, 1, 0, 0);
      add("r_hold_3",          0, 0, 20, 15, 10, 10, 50, 50,   0, 1, 1, 0, 1, 0, 0);
      add("r_hold_4",          0, 0, 20, 15, 10, 10, 50, 50,   0, 1, 1, 0, 1, 0, 0);
      add("r_release",         0, 0, 20, 15, 10, 10, 50, 50,   1, 1, 1, 0, 1, 0, 0);
      add("right_hit_nowrap",  0, 0, 39, 63, 10, 60, 50, 50,   1, 1, 1, 0, 1, 0, 0);
      add("left_hit_nowrap",   0, 0,  0, 63, 60, 60, 50, 50,   1, 1, 1, 0, 1, 0, 0);
      add("draw_running",      0, 0, 20, 15, 10, 10, 20, 15,   1, 1, 1, 0, 1, 0, 1);

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].st, tbl[i].bx, tbl[i].by, tbl[i].p1, tbl[i].p2, tbl[i].col, tbl[i].row);
         step();
         check(tbl[i].name, dut_bundle(),
               pack(tbl[i].en, tbl[i].s1, tbl[i].s2, tbl[i].pulse, tbl[i].act, tbl[i].win, tbl[i].draw));
      end

      // Ball parked on the left wall: one arrival, one point.
      pulses = 0;
      zeros  = 0;
      drive(0, 0, 0, 5, 10, 10, 50, 50);
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus.point_pulse) pulses++;
         if (!bus.ball_enable) zeros++;
      end
      check("wall_pulses",   32'(pulses), 32'd1);
      check("wall_hold_len", 32'(zeros), 32'(HOLD));
      check("wall_score2",   32'(bus.score2), 32'd2);
      check("wall_enable",   32'(bus.ball_enable), 32'd1);

      // Third right-player point ends the game without a hold.
      drive(0, 0, 20, 15, 10, 10, 50, 50);
      step();
      drive(0, 0, 0, 5, 10, 10, 50, 50);
      step();
      check("game_over", dut_bundle(), pack(0, 1, 3, 1, 0, 2, 0));
      drive(0, 0, 20, 15, 10, 10, 50, 50);
      for (int i = 0; i < 6; i++) begin
         step();
         check("game_over_stay", dut_bundle(), pack(0, 1, 3, 0, 0, 2, 0));
      end
      drive(0, 1, 20, 15, 10, 10, 50, 50);
      step();
      check("restart", dut_bundle(), pack(1, 0, 0, 0, 1, 0, 0));

      // Reset during the point hold, with start asserted on the reset cycle.
      drive(0, 0, 39, 40, 10, 10, 50, 50);
      step();
      check("rmh_miss", dut_bundle(), pack(0, 1, 0, 1, 1, 0, 0));
      drive(1, 1, 20, 15, 10, 10, 20, 15);
      step();
      check("rmh_reset", dut_bundle(), pack(0, 0, 0, 0, 0, 0, 0));
      drive(0, 0, 20, 15, 10, 10, 20, 15);
      step();
      check("rmh_idle", dut_bundle(), pack(0, 0, 0, 0, 0, 0, 0));

      // Random play against the model.
      drive(1, 0, 20, 15, 10, 10, 50, 50);
      step();
      bx = 20; by = 15; p1 = 10; p2 = 10;
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 5))
            0:       bx = 0;
            1:       bx = GW - 1;
            2, 3:    bx = bx;
            default: bx = $urandom_range(0, GW - 1);
         endcase
         if ($urandom_range(0, 2) == 0) by = $urandom_range(0, 63);
         if ($urandom_range(0, 15) == 0) p1 = $urandom_range(0, 63);
         if ($urandom_range(0, 15) == 0) p2 = $urandom_range(0, 63);
         if ($urandom_range(0, 1) == 0)
            drive($urandom_range(0, 299) == 0, $urandom_range(0, 19) == 0, bx, by, p1, p2, bx, by);
         else
            drive($urandom_range(0, 299) == 0, $urandom_range(0, 19) == 0, bx, by, p1, p2,
                  $urandom_range(0, 63), $urandom_range(0, 63));
         step();
         check("random", dut_bundle(), model_bundle());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
